key_filter_bank: RTL

Multi-channel, parametrised key conditioning block, replacing the single-bit registered key-to-LED path with a full front end. Each channel synchronises a raw active-low push-button input, debounces it with a per-channel counter and produces a stable level, single-cycle press/release pulses and an LED drive output. The LED output can follow the key or toggle on each press. It sits between the board key pins and any LED or control logic in the design.

---
 rtl/key_filter_pkg.sv | 17 +
 rtl/key_filter_ch.sv | 95 +++++++++
 rtl/key_filter_bank.sv | 36 +++
 3 files changed

// File: rtl/key_filter_pkg.sv
// Shared types, defaults and helpers for the key filter bank.
// Toggle-mode LEDs are compiled in only when KEY_FILTER_TOGGLE_EN is defined.
package key_filter_pkg;

    typedef enum logic {
        MODE_FOLLOW = 1'b0,
        MODE_TOGGLE = 1'b1
    } led_mode_e;

    localparam int CNT_MAX_20MS    = 1_000_000;
    localparam int SYNC_STAGES_DEF = 2;

    function automatic int cnt_width(input int cnt_max);
        return (cnt_max < 1) ? 1 : $clog2(cnt_max + 1);
    endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: synchroniser, debounce counter, edge pulses and LED drive.
// Toggle-mode LED logic exists only when KEY_FILTER_TOGGLE_EN is defined.
module key_filter_ch
    import key_filter_pkg::*;
#(
    parameter int CNT_MAX     = CNT_MAX_20MS,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    input  logic i_mode,
    output logic o_state,
    output logic o_press,
    output logic o_release,
    output logic o_led
);

    localparam int CW = cnt_width(CNT_MAX);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_state;
    logic                   r_press;
    logic                   r_release;
    logic                   r_led;

    logic w_s;
    logic w_match;
    logic w_done;
    logic w_fire;
    logic w_state_nxt;

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_match = (w_s == r_state);
    assign w_done  = (r_cnt == CW'(CNT_MAX - 1));
    assign w_fire  = !w_match && w_done;

    always_comb begin
        w_state_nxt = r_state;
        if (w_fire) begin
            w_state_nxt = w_s;
        end
    end

    // Any sample agreeing with the debounced level restarts qualification.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], ~i_key_n};
            if (w_match || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_state   <= w_state_nxt;
            r_press   <= w_fire && w_s;
            r_release <= w_fire && !w_s;
        end
    end

`ifdef KEY_FILTER_TOGGLE_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led <= 1'b0;
        end else if (i_mode == MODE_FOLLOW) begin
            r_led <= w_state_nxt;
        end else if (r_press) begin
            r_led <= ~r_led;
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = i_mode;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_state_nxt;
        end
    end
`endif

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_led     = r_led;

endmodule

// File: rtl/key_filter_bank.sv
// Bank of CH independent debounced key channels with LED drive.
// Define KEY_FILTER_TOGGLE_EN to enable per-channel toggle-mode LEDs.
module key_filter_bank
    import key_filter_pkg::*;
#(
    parameter int CH          = 4,
    parameter int CNT_MAX     = CNT_MAX_20MS,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [CH-1:0] key_in,
    input  logic [CH-1:0] mode,
    output logic [CH-1:0] key_state,
    output logic [CH-1:0] key_press,
    output logic [CH-1:0] key_release,
    output logic [CH-1:0] led_out
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        key_filter_ch #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .i_clk     (sys_clk),
            .i_rst     (sys_rst),
            .i_key_n   (key_in[g]),
            .i_mode    (mode[g]),
            .o_state   (key_state[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g]),
            .o_led     (led_out[g])
        );
    end

endmodule
